// File: rtl/reg_file.sv
// reg_file: DEPTH x WIDTH register file with one synchronous write port and
// one asynchronous (combinational) read port. Built from a one-hot write
// decoder, per-entry enabled registers and a one-hot read multiplexer.
// Every entry clears immediately when rst_n is low.
//
// Optional build macro REG_FILE_BYPASS_EN: when defined, a same-address
// write is forwarded to data_out combinationally in the cycle of the write.
// When undefined, data_out always shows stored contents.
// Stored state and write timing are the same in both builds.
`timescale 1ns/100ps

module reg_file #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  data_in,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  data_out
);

    // One-hot write enables. An address at or beyond DEPTH matches no
    // entry, so such writes are dropped without extra logic. When we is 0,
    // every enable is forced low, so an unknown waddr cannot disturb
    // stored state.
    logic [DEPTH-1:0] wr_en;

    // One-hot read selects. An address at or beyond DEPTH selects nothing,
    // so the read multiplexer returns 0.
    logic [DEPTH-1:0] rd_sel;

    // Storage and next-state for each entry.
    logic [WIDTH-1:0] entry_q [DEPTH];
    logic [WIDTH-1:0] entry_d [DEPTH];

    // Value read from storage before any bypass is applied.
    logic [WIDTH-1:0] rd_data;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign wr_en[gi]   = we & (waddr == ADDR_W'(gi));
            assign rd_sel[gi]  = (raddr == ADDR_W'(gi));
            assign entry_d[gi] = wr_en[gi] ? data_in : entry_q[gi];
        end
    endgenerate

    // Entry registers: asynchronous clear, otherwise load next-state on clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

    // Read multiplexer: AND-OR of the one-hot selected entry.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rd_data = rd_data | (rd_sel[i] ? entry_q[i] : '0);
        end
    end

`ifdef REG_FILE_BYPASS_EN
    // A write hits a real entry exactly when some decoder output is active.
    logic write_hit;
    assign write_hit = |wr_en;

    // Output select: forward the write data on a same-address write,
    // otherwise show the stored entry.
    always_comb begin
        data_out = rd_data;
        if (rst_n && write_hit && (raddr == waddr)) begin
            data_out = data_in;
        end
    end
`else
    // Output select: stored contents only; a same-address write shows the
    // old value until the clock edge.
    always_comb begin
        data_out = rd_data;
    end
`endif

endmodule

// File: tb/tb_reg_file.sv
// Testbench for reg_file: directed steps with a scoreboard of expected read
// values. It drives a power-of-two instance (DEPTH=4) and a
// non-power-of-two instance (DEPTH=3).
`timescale 1ns/100ps

module tb_reg_file;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       we;
    logic [1:0] waddr;
    logic [3:0] data_in;
    logic [1:0] raddr;
    logic [3:0] data_out;

    logic       we3;
    logic [1:0] waddr3;
    logic [3:0] data_in3;
    logic [1:0] raddr3;
    logic [3:0] data_out3;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_q [$];
    logic [3:0] model  [4];
    logic [3:0] model3 [3];

    reg_file #(.WIDTH(4), .DEPTH(4), .ADDR_W(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .waddr    (waddr),
        .data_in  (data_in),
        .raddr    (raddr),
        .data_out (data_out)
    );

    reg_file #(.WIDTH(4), .DEPTH(3), .ADDR_W(2)) dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we3),
        .waddr    (waddr3),
        .data_in  (data_in3),
        .raddr    (raddr3),
        .data_out (data_out3)
    );

    always #1 clk = ~clk;

    // Pop the oldest expectation and compare it with the observed value.
    task automatic chk(input string tag, input logic [3:0] obs);
        logic [3:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    // Read the DEPTH=4 instance and check it against the model.
    task automatic rd(input string tag, input int a);
        raddr = 2'(a);
        exp_q.push_back(model[a]);
        #0.2;
        chk(tag, data_out);
        $display("read %s raddr=%0d data_out=%h", tag, a, data_out);
    endtask

    // Read the DEPTH=3 instance; addresses past the end read 0.
    task automatic rd3(input string tag, input int a);
        raddr3 = 2'(a);
        exp_q.push_back(a < 3 ? model3[a] : 4'h0);
        #0.2;
        chk(tag, data_out3);
        $display("read %s raddr=%0d data_out=%h", tag, a, data_out3);
    endtask

    // Write one entry of the DEPTH=4 instance in a single cycle.
    task automatic wr(input int a, input logic [3:0] d);
        @(negedge clk);
        we = 1'b1; waddr = 2'(a); data_in = d;
        @(posedge clk);
        model[a] = d;
        $display("write waddr=%0d data_in=%h", a, d);
    endtask

    initial begin
        rst_n = 1'b0;
        we = 1'b0; waddr = '0; data_in = '0; raddr = '0;
        we3 = 1'b0; waddr3 = '0; data_in3 = '0; raddr3 = '0;
        for (int i = 0; i < 4; i++) model[i] = 4'h0;
        for (int i = 0; i < 3; i++) model3[i] = 4'h0;

        // Reset state.
        @(negedge clk);
        for (int i = 0; i < 4; i++) rd($sformatf("reset_rd%0d", i), i);
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential fill, one write per cycle.
        for (int i = 0; i < 4; i++) wr(i, 4'hA + 4'(i));
        @(negedge clk);
        we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rd($sformatf("fill_rd%0d", i), i);
        end

        // Write disable: sweep waddr with we low.
        data_in = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            waddr = 2'(i);
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rd($sformatf("wedis_rd%0d", i), i);
        end

        // Overwrite entry 2, others isolated.
        wr(2, 4'h5);
        @(negedge clk);
        we = 1'b0;
        for (int i = 0; i < 4; i++) rd($sformatf("ovw_rd%0d", i), i);

        // Read-during-write on entry 1.
        @(negedge clk);
        raddr = 2'd1; waddr = 2'd1; data_in = 4'h7; we = 1'b1;
`ifdef REG_FILE_BYPASS_EN
        exp_q.push_back(4'h7);
`else
        exp_q.push_back(4'hB);
`endif
        #0.2;
        chk("rdw_before_edge", data_out);
        $display("rdw before edge data_out=%h", data_out);
        @(posedge clk);
        model[1] = 4'h7;
        #0.2;
        exp_q.push_back(4'h7);
        chk("rdw_after_edge", data_out);
        $display("rdw after edge data_out=%h", data_out);
        @(negedge clk);
        we = 1'b0;

        // Asynchronous reset mid-cycle: entries clear before any clk edge.
        @(negedge clk);
        #0.1;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = 4'h0;
        for (int i = 0; i < 4; i++) rd($sformatf("async_rst_rd%0d", i), i);

        // A write attempted while reset is held is ignored.
        @(negedge clk);
        we = 1'b1; waddr = 2'd0; data_in = 4'h3;
        @(posedge clk);
        #0.2;
        rd("wr_in_reset", 0);
        @(negedge clk);
        we = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        rd("after_rst_release", 0);

        // Non-power-of-two instance: fill then write past the end.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            we3 = 1'b1; waddr3 = 2'(i); data_in3 = 4'h1 + 4'(i);
            @(posedge clk);
            model3[i] = 4'h1 + 4'(i);
            $display("write3 waddr=%0d data_in=%h", i, data_in3);
        end
        @(negedge clk);
        we3 = 1'b1; waddr3 = 2'd3; data_in3 = 4'h9;
        rd3("oob_rd3_during_write", 3);
        @(negedge clk);
        we3 = 1'b0;
        for (int i = 0; i < 4; i++) rd3($sformatf("oob_rd%0d", i), i);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Small synchronous-write, asynchronous-read register file.
- DEPTH entries of WIDTH bits each, with one write port and one read port.
- Used as general-purpose scratch storage in datapaths.
- Built from a write-address decoder, per-entry clock-enabled registers and a read multiplexer.

Parameters:
- WIDTH, 4, data width of each entry in bits.
- DEPTH, 4, number of entries; legal range 2..256.
- ADDR_W, 2, address width; must satisfy 2**ADDR_W >= DEPTH.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- we  input  1  write enable, sampled on rising clk.
- waddr  input  ADDR_W  write address.
- data_in  input  WIDTH  write data.
- raddr  input  ADDR_W  read address.
- data_out  output  WIDTH  read data, combinational from raddr and stored state.

Interface note: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset:
  - rst_n low immediately clears every entry to 0, independent of clk; data_out therefore reads 0.
  - Deassertion is synchronized externally by the system; no write occurs on the edge where rst_n is low.
- Write:
  - Occurs on rising clk when rst_n=1, we=1 and waddr < DEPTH.
  - Entry[waddr] <= data_in; all other entries are unchanged.
  - Write latency is 1 cycle: the new value is visible on data_out (when raddr=waddr) immediately after that edge.
  - we=0: no entry changes, regardless of waddr and data_in.
  - waddr >= DEPTH (only possible when DEPTH is not a power of two): the write is silently dropped.
- Read:
  - data_out = entry[raddr], purely combinational, with 0-cycle latency.
  - raddr >= DEPTH: data_out = 0.
  - raddr or waddr unknown/X: no requirement on data_out; stored state must not be corrupted when we=0.
- Read-during-write, same address, same cycle:
  - Without the optional feature, data_out shows the old stored value until the clock edge, then the new one.
- Simultaneous write and reset: reset wins and the entry stays 0.
- Write decode is one-hot: at most one entry is enabled per cycle.
- No internal pipelining, handshake or state machine.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined: write-through bypass. When we=1, rst_n=1, raddr==waddr and waddr < DEPTH, data_out = data_in combinationally, in the same cycle as the write. Otherwise data_out behaves normally.
- Undefined: no bypass; data_out always reflects stored contents (old value during a same-address write).
- Stored state and write timing are identical in both builds.

Test Plan:
- Reset: pulse rst_n low mid-cycle after entries were written -> all four entries read 0 for raddr 0..3 immediately, without waiting for a clk edge.
- Sequential fill (clk period 2 ns, we=1):
  - Stimulus: data_in=4'hA/waddr=0, then 4'hB/1, 4'hC/2, 4'hD/3, one per cycle; then we=0.
  - Response: raddr=0,1,2,3 in successive cycles -> data_out = A, B, C, D.
- Write disable: with contents A,B,C,D, set we=0, data_in=4'hF, and sweep waddr 0..3 over 4 cycles -> readback remains A,B,C,D.
- Overwrite and isolation: write 4'h5 to entry 2 -> raddr=2 gives 5; raddr=0,1,3 still give A,B,D.
- Read-during-write:
  - Setup: raddr=waddr=1, entry1=B, we=1, data_in=4'h7.
  - Bypass off: data_out=B before the edge, 7 after it.
  - Bypass on: data_out=7 already before the edge.
- Non-power-of-two build: DEPTH=3, ADDR_W=2; write 4'h9 to waddr=3 -> entries 0..2 unchanged; raddr=3 reads 0.
